// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: ALU writeback, MDU result handshake, MDU issue,
// decode hazard query and the register-file write port.
//
// Handshake: the MDU result transfers on a rising edge where mdu_valid and
// mdu_ready are both 1. mdu_ready never depends on mdu_valid in the same
// cycle. The ALU writeback has no ready; alu_valid must be 0 while wb_stall=1.
interface regfile_wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard_stall;
    logic        wb_stall;
    logic        wrtEn;
    logic [4:0]  wrtReg;
    logic [31:0] wrtData;
    logic [31:0] pending;

    // Pipeline side: drives writebacks, MDU results/issues and decode regs
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mdu_valid, mdu_rd, mdu_data,
        output mdu_issue, mdu_issue_rd,
        output chk_rs1, chk_rs2, chk_rd,
        input  mdu_ready, hazard_stall, wb_stall,
        input  wrtEn, wrtReg, wrtData, pending
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mdu_valid, mdu_rd, mdu_data,
        input  mdu_issue, mdu_issue_rd,
        input  chk_rs1, chk_rs2, chk_rd,
        output mdu_ready, hazard_stall, wb_stall,
        output wrtEn, wrtReg, wrtData, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between the ALU
// (no back-pressure) and the MDU (valid/ready) using a one-entry MDU buffer,
// a starvation counter that freezes writeback, and a pending-write scoreboard.
module regfile_wb_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    logic        buf_valid;
    logic [4:0]  buf_rd;
    logic [31:0] buf_data;
    logic [2:0]  starve_cnt;
    logic        wb_stall_q;
    logic [31:0] pend_q;
    logic [31:0] pend_next;

    logic        alu_write;
    logic        alu_take;
    logic        drain;
    logic        ready;
    logic        mdu_hs;
    logic        mdu_direct;
    logic        buf_load;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        mdu_src_wr;

    // Port arbitration: buffer under wb_stall, then ALU, then buffer, then direct MDU
    always_comb begin
        alu_write  = bus.alu_valid && (bus.alu_rd != 5'd0);
        // While frozen the ALU write is a protocol violation and is dropped
        alu_take   = alu_write && !wb_stall_q;
        drain      = buf_valid && (wb_stall_q || !alu_take);
        // Derived from buffer state and ALU only, never from mdu_valid
        ready      = rst || !buf_valid || drain;
        mdu_hs     = bus.mdu_valid && ready && !rst;
        mdu_direct = mdu_hs && !buf_valid && !alu_take && (bus.mdu_rd != 5'd0);
        // Results for x0 are accepted and simply never stored
        buf_load   = mdu_hs && (bus.mdu_rd != 5'd0) && !mdu_direct;
    end

    // Write-port drive; everything is zero when no write happens or in reset
    always_comb begin
        wr_en      = 1'b0;
        wr_reg     = 5'd0;
        wr_data    = 32'd0;
        mdu_src_wr = 1'b0;
        if (!rst) begin
            if (drain) begin
                wr_en      = 1'b1;
                wr_reg     = buf_rd;
                wr_data    = buf_data;
                mdu_src_wr = 1'b1;
            end else if (alu_take) begin
                wr_en      = 1'b1;
                wr_reg     = bus.alu_rd;
                wr_data    = bus.alu_data;
            end else if (mdu_direct) begin
                wr_en      = 1'b1;
                wr_reg     = bus.mdu_rd;
                wr_data    = bus.mdu_data;
                mdu_src_wr = 1'b1;
            end
        end
    end

    // Scoreboard next value: MDU write clears, issue sets, set wins on overlap
    always_comb begin
        pend_next = pend_q;
        if (mdu_src_wr) begin
            pend_next[wr_reg] = 1'b0;
        end
        if (bus.mdu_issue && (bus.mdu_issue_rd != 5'd0)) begin
            pend_next[bus.mdu_issue_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // One-entry MDU result buffer; a drain and a new load may share a cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_rd    <= 5'd0;
            buf_data  <= 32'd0;
        end else if (buf_load) begin
            buf_valid <= 1'b1;
            buf_rd    <= bus.mdu_rd;
            buf_data  <= bus.mdu_data;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

    // Starvation counter and the registered writeback freeze request
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
            wb_stall_q <= 1'b0;
        end else begin
            if (!buf_valid || drain) begin
                starve_cnt <= 3'd0;
            end else if (starve_cnt != 3'd7) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
            if (drain) begin
                wb_stall_q <= 1'b0;
            end else if (buf_valid && (starve_cnt >= 3'd3)) begin
                wb_stall_q <= 1'b1;
            end
        end
    end

    // Pending-write scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 32'd0;
        end else begin
            pend_q <= pend_next;
        end
    end

    assign bus.mdu_ready    = ready;
    assign bus.wb_stall     = wb_stall_q;
    assign bus.wrtEn        = wr_en;
    assign bus.wrtReg       = wr_reg;
    assign bus.wrtData      = wr_data;
    assign bus.pending      = pend_q;
    assign bus.hazard_stall = pend_q[bus.chk_rs1] | pend_q[bus.chk_rs2] | pend_q[bus.chk_rd];
endmodule
